mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width of all ports.
REQ-002 SHALL have parameter: DATA_W, 32, data width of all ports; DATA_W/8 byte-mask bits.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch request, held until i_ack.
- i_addr  in  ADDR_W  fetch address, stable while i_req.
- i_ack  out  1  one-cycle pulse; fetch complete.
- i_rdata  out  DATA_W  fetched word, valid with i_ack.
- d_req  in  1  data request from load/store stage (mem_rd|mem_wr), held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  store byte enables.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- m_req  out  1  shared memory request, held until m_ready.
- m_we  out  1  shared memory write enable.
- m_addr  out  ADDR_W  shared memory address.
- m_wdata  out  DATA_W  shared memory write data.
- m_wmask  out  DATA_W/8  shared memory byte enables.
- m_ready  in  1  one-cycle completion pulse from memory.
- m_rdata  in  DATA_W  read data, valid with m_ready.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-005 IDLE: if any request, SHALL select winner, register winner's addr/we/wdata/wmask into m_* (i side: m_we=0, m_wmask=0), go to ISSUE; else stay IDLE.
REQ-006 ISSUE: SHALL hold m_req=1 and all m_* stable; on m_ready SHALL register m_rdata into winner's rdata and go to RESP.
REQ-007 RESP: SHALL pulse winner's ack for exactly one cycle, m_req=0, go to IDLE; requests SHALL be ignored in RESP.
REQ-008 m_req SHALL be 1 only in ISSUE.
REQ-009 Latency: request seen in IDLE at cycle 0 -> m_req at cycle 1; m_ready at cycle k>=1 -> ack at cycle k+1; minimum 3 cycles req-to-ack.
REQ-010 Fixed priority (macro absent): d_req SHALL win over i_req when both asserted in IDLE.
REQ-011 i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-012 Non-winning requester's rdata SHALL hold its previous value.
REQ-013 m_ready outside ISSUE SHALL be ignored with no state change.
REQ-014 Requester dropping req before ack SHALL NOT abort an issued transaction; ack still pulses.
REQ-015 Store (d_we=1) SHALL still produce d_ack; d_rdata updated with m_rdata (don't-care content).

Reset
REQ-016 On reset assertion, SHALL asynchronously force state IDLE, m_req=0, i_ack=0, d_ack=0, m_we=0, m_addr=0, m_wdata=0, m_wmask=0, i_rdata=0, d_rdata=0, last_grant=I.
REQ-017 Reset mid-transaction SHALL abandon it: no ack generated; first post-reset arbitration from IDLE.

Configuration
REQ-018 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous i_req and d_req in IDLE, SHALL grant the requester not granted last; last_grant updated on every grant; after reset, d wins first tie.
REQ-019 Macro undefined: fixed d-over-i priority per REQ-010; last_grant register absent.

Verification
REQ-020 i_req=1, i_addr=0x100, m_ready at cycle 3 with m_rdata=0x00500093 -> m_req cycles 1-3, m_addr=0x100, m_we=0, i_ack pulse cycle 4, i_rdata=0x00500093.
REQ-021 d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=0xF, m_ready at cycle 1 -> m_we=1, m_wdata=0xDEADBEEF, m_wmask=0xF, d_ack cycle 2.
REQ-022 i_req and d_req both asserted continuously, fixed priority -> d granted first, i granted next IDLE after d_ack; never both acks in one cycle.
REQ-023 With ARB_ROUND_ROBIN_EN, both requesters held for four transactions -> grant order d, i, d, i.
REQ-024 reset asserted in ISSUE, m_ready pulsed one cycle after release -> m_req drops immediately, no ack, stray m_ready ignored, all outputs at reset values.
REQ-025 Stray m_ready in IDLE with no requests -> no ack, outputs unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory port; IDLE->ISSUE->RESP, min 3 cycles req-to-ack.
// Optional macro ARB_ROUND_ROBIN_EN alternates ties between requesters; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;
  logic   grant_d;
  logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_d = 0 means the fetch side won last, so data wins the first tie after reset.
  logic last_grant_d;

  assign pick_d = d_req & (~i_req | ~last_grant_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_grant_d <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = ISSUE;
      ISSUE:   if (m_ready)        state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_d <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wmask <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == IDLE && (i_req || d_req)) begin
        grant_d <= pick_d;
        if (pick_d) begin
          m_we    <= d_we;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_wmask <= d_wmask;
        end else begin
          m_we    <= 1'b0;
          m_addr  <= i_addr;
          m_wmask <= '0;
        end
      end
      // Read data is captured for stores too; the store side simply ignores it.
      if (state == ISSUE && m_ready) begin
        if (grant_d) d_rdata <= m_rdata;
        else         i_rdata <= m_rdata;
      end
    end
  end

  assign m_req = (state == ISSUE);
  assign i_ack = (state == RESP) & ~grant_d;
  assign d_ack = (state == RESP) &  grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: expected grants queued at stimulus, checked at memory issue and ack.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wmask;
  logic        i_ack, d_ack, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wmask;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.we = is_d & we; e.addr = addr; e.wdata = wdata;
    e.wmask = (is_d && we) ? wmask : 4'h0; e.rdata = rdata;
    exp_q.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wmask = wmask;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
  endtask

  // Plays the memory: expects m_req one cycle after an IDLE cycle, answers after mem_delay cycles.
  task automatic serve(input int mem_delay, input bit drop_at_ack, input bit drop_early);
    exp_t e;
    int   waited = 0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    while (!m_req && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("m_req_latency", waited, 1);
    if (!m_req) return;
    chk("m_addr", m_addr, e.addr);
    chk("m_we", m_we, e.we);
    chk("m_wmask", m_wmask, e.wmask);
    if (e.we) chk("m_wdata", m_wdata, e.wdata);
    if (drop_early) begin
      if (e.is_d) d_req = 1'b0; else i_req = 1'b0;
    end
    for (int c = 0; c < mem_delay; c++) begin
      chk("no_early_ack", i_ack | d_ack, 0);
      @(negedge clk);
      chk("m_req_hold", m_req, 1);
      chk("m_addr_hold", m_addr, e.addr);
    end
    m_ready = 1'b1;
    m_rdata = e.rdata;
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = $urandom;
    chk("ack_exclusive", i_ack & d_ack, 0);
    chk("m_req_in_resp", m_req, 0);
    if (e.is_d) begin
      chk("d_ack", d_ack, 1);
      chk("d_rdata", d_rdata, e.rdata);
      chk("i_rdata_hold", i_rdata, last_i);
      last_d = e.rdata;
    end else begin
      chk("i_ack", i_ack, 1);
      chk("i_rdata", i_rdata, e.rdata);
      chk("d_rdata_hold", d_rdata, last_d);
      last_i = e.rdata;
    end
    if (drop_at_ack) begin
      if (e.is_d) d_req = 1'b0; else i_req = 1'b0;
    end
    @(negedge clk);
    chk("ack_one_cycle", {i_ack, d_ack}, 2'b00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_acks"}, {i_ack, d_ack}, 2'b00);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wmask"}, m_wmask, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_snap;
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; m_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Fetch, memory answers at cycle 3.
    issue(0, 0, 32'h100, 32'h0, 4'h0, 32'h00500093);
    serve(2, 1, 0);

    // Store, memory answers at cycle 1.
    issue(1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 32'h12345678);
    serve(0, 1, 0);

    // Load on the data side.
    issue(1, 0, 32'h2004, 32'h0, 4'h0, 32'hCAFE0001);
    serve(1, 1, 0);

    // Both held: data first, fetch in the next IDLE.
    issue(1, 0, 32'h3000, 32'h0, 4'h0, 32'hAAAA0000);
    issue(0, 0, 32'h0400, 32'h0, 4'h0, 32'hBBBB0000);
    serve(1, 1, 0);
    serve(0, 1, 0);

    // Requester withdraws after issue; ack must still arrive.
    issue(0, 0, 32'h0500, 32'h0, 4'h0, 32'h0BADF00D);
    serve(1, 0, 1);

    // Stray m_ready in IDLE.
    a_snap = m_addr;
    m_ready = 1'b1; m_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    m_ready = 1'b0;
    chk("stray_acks", {i_ack, d_ack}, 2'b00);
    chk("stray_m_req", m_req, 0);
    chk("stray_i_rdata", i_rdata, last_i);
    chk("stray_d_rdata", d_rdata, last_d);
    chk("stray_m_addr", m_addr, a_snap);
    @(negedge clk);
    chk("stray_acks2", {i_ack, d_ack}, 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
    // Both held through four grants: d, i, d, i.
    issue(1, 0, 32'h6000, 32'h0, 4'h0, 32'h11110000);
    issue(0, 0, 32'h0600, 32'h0, 4'h0, 32'h22220000);
    issue(1, 0, 32'h6000, 32'h0, 4'h0, 32'h33330000);
    issue(0, 0, 32'h0600, 32'h0, 4'h0, 32'h44440000);
    serve(0, 0, 0);
    serve(1, 0, 0);
    serve(0, 0, 0);
    d_req = 1'b0;
    serve(1, 1, 0);
`endif

    // Random mix of single transactions.
    for (int n = 0; n < 8; n++) begin
      bit is_d = $urandom_range(0, 1) == 1;
      issue(is_d, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
            4'($urandom_range(0, 15)), $urandom);
      serve($urandom_range(0, 3), 1, 0);
    end

    // Reset while ISSUE is outstanding.
    i_req = 1'b1; i_addr = 32'h0700;
    @(negedge clk);
    chk("rst_pre_m_req", m_req, 1);
    #2 reset = 1'b1;
    #1 chk("rst_m_req_async", m_req, 0);
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'h77777777;
    @(negedge clk);
    m_ready = 1'b0;
    chk_reset_vals("post_rst");
    @(negedge clk);
    chk_reset_vals("post_rst2");
    last_i = '0; last_d = '0;

    // First tie after reset goes to data in either build.
    issue(1, 1, 32'h8000, 32'h55AA55AA, 4'h3, 32'h0);
    issue(0, 0, 32'h0800, 32'h0, 4'h0, 32'h99990000);
    serve(0, 1, 0);
    serve(2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
